neureka_streamer_sequencer: RTL and testbench
=============================================

Name: neureka_streamer_sequencer

Overview:
- Sequences the shared streamer (one load source, dedicated weight source, one sink, TCDM FIFO) through the load/store phases of one tile job.
- Accepts a job mask from the tile controller and issues phases in fixed priority.
- For each phase it drives the mux selects, emits clear and start pulses, and waits for the done flag.
- Drains the TCDM FIFO before any load/store direction change.

Parameters:
- CNT_W, 32, width of the optional wait-cycle counter.
- FW_EN_DEFAULT, 1, reset value of the feat+weight overlap enable register.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- clear_i  in  1  synchronous soft clear
- enable_i  in  1  global enable; low freezes the FSM
- job_valid_i  in  1  job request
- job_ready_o  out  1  job accepted when valid&ready
- job_mask_i  in  5  phase mask: bit0 feat, bit1 weight, bit2 norm, bit3 streamin, bit4 store
- job_wmem_i  in  1  weights come from the dedicated weight port
- job_fw_i  in  1  merge feat+weight into a single LD_FEAT_WEIGHT phase
- ld_which_sel_o  out  3  ld_which encoding (package)
- ld_st_sel_o  out  1  0 = load, 1 = store
- wmem_sel_o  out  1  dedicated weight port select
- clear_source_o  out  1  1-cycle pulse
- clear_sink_o  out  1  1-cycle pulse
- clear_fifo_o  out  1  1-cycle pulse
- src_start_o  out  1  1-cycle source start pulse
- sink_start_o  out  1  1-cycle sink start pulse
- src_done_i  in  1  source done
- sink_done_i  in  1  sink done
- fifo_empty_i  in  1  TCDM FIFO empty
- phase_done_o  out  1  1-cycle pulse at end of each phase
- job_done_o  out  1  1-cycle pulse at end of the job
- busy_o  out  1  high when state is not IDLE

Behaviour:
- Reset / clear_i:
  - state IDLE; pending mask = 0; direction register = 0 (load).
  - ld_which_sel_o = LD_FEAT_SEL (0); all other outputs 0.
  - job_ready_o = (state == IDLE) & enable_i & ~clear_i.
- enable_i low: state and registers hold; all pulse outputs are forced to 0; held selects stay unchanged.
- FSM states and transitions:
  - IDLE: on accept at cycle T, latch mask, wmem and fw flags → PICK.
  - PICK:
    - pending == 0 → DONE.
    - Otherwise pick by priority feat > weight > norm > streamin > store.
    - If the fw flag is set and both feat and weight are pending, pick LD_FEAT_WEIGHT, which retires both bits.
    - If the picked direction differs from the direction register and fifo_empty_i = 0 → DRAIN; else → CLEAR.
  - DRAIN: wait for fifo_empty_i = 1 → CLEAR.
  - CLEAR (1 cycle):
    - Register ld_which_sel_o, ld_st_sel_o and wmem_sel_o.
    - wmem_sel_o = latched wmem flag only for weight or feat-weight phases, else 0.
    - Pulse clear_source_o for load phases, clear_sink_o for store.
    - Pulse clear_fifo_o if the direction changed; update the direction register.
  - START (1 cycle): pulse src_start_o or sink_start_o.
  - WAIT:
    - Load phases sample src_done_i; store samples sink_done_i. done is ignored in every other state.
    - On done: clear the pending bit(s), pulse phase_done_o → PICK.
  - DONE: pulse job_done_o → IDLE.
- Selects stay stable from CLEAR until the next CLEAR, including across IDLE, so the datapath never sees glitching selects.
- Latency, with accept at T and no drain:
  - CLEAR at T+2, START at T+3, WAIT from T+4.
  - done seen at D → next phase CLEAR at D+2.
  - Empty mask → job_done_o at T+2.
- A done pulse arriving together with enable_i low is lost; the producer holds done until start, per streamer semantics.
- Mid-job clear_i aborts immediately and no done pulses follow.

Optional Feature:
- Macro: NEUREKA_SEQ_PERF_CNT_EN.
- Defined:
  - Adds output wait_cycles_o [CNT_W-1:0].
  - Counts cycles spent in WAIT or DRAIN with enable_i high; zeroed on job accept, reset and clear_i.
  - Saturates at all-ones; holds its value after job_done_o.
- Undefined: port and counter are absent; behaviour is otherwise identical.

Decomposition:
- neureka_package holds:
  - ld_which encodings: LD_FEAT_SEL = 0, LD_WEIGHT_SEL = 1, LD_NORM_SEL = 2, LD_STREAMIN_SEL = 3, LD_FEAT_WEIGHT_SEL = 4.
  - seq_state_t enum: IDLE, PICK, DRAIN, CLEAR, START, WAIT, DONE.
  - Phase mask bit-index constants.
- Sub-module neureka_seq_phase_pick (combinational):
  - Inputs: pending mask, fw flag.
  - Outputs: ld_which code, store flag, retire mask.

Test Plan:
- Mask 5'b00001, fifo empty, src_done 3 cycles after start:
  - ld_which = 0 and clear_source pulse at T+2, src_start at T+3.
  - phase_done then job_done 2 cycles later.
- Mask 5'b10011, fw = 1, wmem = 1:
  - One phase with ld_which = 4 and wmem_sel = 1.
  - Then store: with fifo_empty low for 5 cycles, the FSM sits in DRAIN.
  - Then clear_fifo and clear_sink pulse together, ld_st_sel = 1.
- Mask 5'b01111, fw = 0:
  - Phase order 0, 1, 2, 3 with exactly four phase_done pulses.
  - wmem_sel = 0 throughout when wmem = 0.
- Mask 0 → job_done at T+2, no clear or start pulses, selects unchanged.
- enable_i low in START, then clear_i mid-WAIT:
  - No pulse while disabled.
  - After clear: state IDLE, job_ready = 1, no phase_done.
  - rst_i mid-job → all outputs at reset values.
- With the perf macro defined: 7 WAIT cycles + 4 DRAIN cycles → wait_cycles_o = 11.

Source files
------------

// File: rtl/neureka_package.sv
// Shared encodings for the streamer sequencer: load-source selects, FSM states
// and the bit positions inside the job phase mask.
package neureka_package;

  localparam int unsigned MASK_W       = 5;
  localparam int unsigned FEAT_BIT     = 0;
  localparam int unsigned WEIGHT_BIT   = 1;
  localparam int unsigned NORM_BIT     = 2;
  localparam int unsigned STREAMIN_BIT = 3;
  localparam int unsigned STORE_BIT    = 4;

  typedef enum logic [2:0] {
    LD_FEAT_SEL        = 3'd0,
    LD_WEIGHT_SEL      = 3'd1,
    LD_NORM_SEL        = 3'd2,
    LD_STREAMIN_SEL    = 3'd3,
    LD_FEAT_WEIGHT_SEL = 3'd4
  } ld_which_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PICK  = 3'd1,
    DRAIN = 3'd2,
    CLEAR = 3'd3,
    START = 3'd4,
    WAIT  = 3'd5,
    DONE  = 3'd6
  } seq_state_t;

endpackage

// File: rtl/neureka_seq_phase_pick.sv
// Fixed-priority phase picker: feat > weight > norm > streamin > store, with an
// optional merged feat+weight phase. Purely combinational.
module neureka_seq_phase_pick
  import neureka_package::*;
(
  input  logic [MASK_W-1:0] pending,
  input  logic              fw,
  output ld_which_t         ld_which,
  output logic              store,
  output logic [MASK_W-1:0] retire
);

  always_comb begin
    ld_which = LD_FEAT_SEL;
    store    = 1'b0;
    retire   = '0;
    if (fw && pending[FEAT_BIT] && pending[WEIGHT_BIT]) begin
      ld_which             = LD_FEAT_WEIGHT_SEL;
      retire[FEAT_BIT]     = 1'b1;
      retire[WEIGHT_BIT]   = 1'b1;
    end else if (pending[FEAT_BIT]) begin
      ld_which             = LD_FEAT_SEL;
      retire[FEAT_BIT]     = 1'b1;
    end else if (pending[WEIGHT_BIT]) begin
      ld_which             = LD_WEIGHT_SEL;
      retire[WEIGHT_BIT]   = 1'b1;
    end else if (pending[NORM_BIT]) begin
      ld_which             = LD_NORM_SEL;
      retire[NORM_BIT]     = 1'b1;
    end else if (pending[STREAMIN_BIT]) begin
      ld_which             = LD_STREAMIN_SEL;
      retire[STREAMIN_BIT] = 1'b1;
    end else if (pending[STORE_BIT]) begin
      // Load mux is irrelevant for the store phase; park it on feat.
      store                = 1'b1;
      retire[STORE_BIT]    = 1'b1;
    end
  end

endmodule

// File: rtl/neureka_streamer_sequencer.sv
// Walks one tile job through its load/store phases on the shared streamer.
// Optional wait-cycle counter enabled by NEUREKA_SEQ_PERF_CNT_EN.
module neureka_streamer_sequencer
  import neureka_package::*;
#(
  parameter int unsigned CNT_W         = 32,
  parameter bit          FW_EN_DEFAULT = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_i,
  input  logic              enable_i,
  input  logic              job_valid_i,
  output logic              job_ready_o,
  input  logic [MASK_W-1:0] job_mask_i,
  input  logic              job_wmem_i,
  input  logic              job_fw_i,
  output logic [2:0]        ld_which_sel_o,
  output logic              ld_st_sel_o,
  output logic              wmem_sel_o,
  output logic              clear_source_o,
  output logic              clear_sink_o,
  output logic              clear_fifo_o,
  output logic              src_start_o,
  output logic              sink_start_o,
  input  logic              src_done_i,
  input  logic              sink_done_i,
  input  logic              fifo_empty_i,
  output logic              phase_done_o,
  output logic              job_done_o,
  output logic              busy_o
`ifdef NEUREKA_SEQ_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  wait_cycles_o
`endif
);

  seq_state_t        state_q, state_d;
  logic [MASK_W-1:0] pending_q;
  logic              wmem_q, fw_q, dir_q;
  ld_which_t         pick_which_q, ld_which_q;
  logic              pick_store_q, ld_st_q, wmem_sel_q;
  logic [MASK_W-1:0] pick_retire_q;

  ld_which_t         pk_which, cur_which;
  logic              pk_store, cur_store;
  logic [MASK_W-1:0] pk_retire;
  logic              accept, live, done_sel;

  neureka_seq_phase_pick u_pick (
    .pending  (pending_q),
    .fw       (fw_q),
    .ld_which (pk_which),
    .store    (pk_store),
    .retire   (pk_retire)
  );

  assign job_ready_o = (state_q == IDLE) & enable_i & ~clear_i;
  assign accept      = job_valid_i & job_ready_o;
  assign live        = enable_i & ~clear_i;
  assign done_sel    = pick_store_q ? sink_done_i : src_done_i;

  // CLEAR can be entered straight from PICK, before the pick registers load.
  assign cur_which = (state_q == PICK) ? pk_which : pick_which_q;
  assign cur_store = (state_q == PICK) ? pk_store : pick_store_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (accept) state_d = PICK;
      PICK: begin
        if (pending_q == '0)                         state_d = DONE;
        else if ((pk_store != dir_q) && !fifo_empty_i) state_d = DRAIN;
        else                                         state_d = CLEAR;
      end
      DRAIN: if (fifo_empty_i) state_d = CLEAR;
      CLEAR: state_d = START;
      START: state_d = WAIT;
      WAIT:  if (done_sel) state_d = PICK;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      pending_q     <= '0;
      wmem_q        <= 1'b0;
      fw_q          <= FW_EN_DEFAULT;
      dir_q         <= 1'b0;
      pick_which_q  <= LD_FEAT_SEL;
      pick_store_q  <= 1'b0;
      pick_retire_q <= '0;
      ld_which_q    <= LD_FEAT_SEL;
      ld_st_q       <= 1'b0;
      wmem_sel_q    <= 1'b0;
    end else if (clear_i) begin
      state_q       <= IDLE;
      pending_q     <= '0;
      wmem_q        <= 1'b0;
      fw_q          <= FW_EN_DEFAULT;
      dir_q         <= 1'b0;
      pick_which_q  <= LD_FEAT_SEL;
      pick_store_q  <= 1'b0;
      pick_retire_q <= '0;
      ld_which_q    <= LD_FEAT_SEL;
      ld_st_q       <= 1'b0;
      wmem_sel_q    <= 1'b0;
    end else if (enable_i) begin
      state_q <= state_d;
      if (accept) begin
        pending_q <= job_mask_i;
        wmem_q    <= job_wmem_i;
        fw_q      <= job_fw_i;
      end
      if (state_q == PICK) begin
        pick_which_q  <= pk_which;
        pick_store_q  <= pk_store;
        pick_retire_q <= pk_retire;
      end
      if (state_d == CLEAR) begin
        ld_which_q <= cur_which;
        ld_st_q    <= cur_store;
        wmem_sel_q <= wmem_q & ((cur_which == LD_WEIGHT_SEL) ||
                                (cur_which == LD_FEAT_WEIGHT_SEL));
      end
      if (state_q == CLEAR) dir_q <= pick_store_q;
      if ((state_q == WAIT) && done_sel) pending_q <= pending_q & ~pick_retire_q;
    end
  end

  assign ld_which_sel_o = ld_which_q;
  assign ld_st_sel_o    = ld_st_q;
  assign wmem_sel_o     = wmem_sel_q;

  assign clear_source_o = live & (state_q == CLEAR) & ~pick_store_q;
  assign clear_sink_o   = live & (state_q == CLEAR) &  pick_store_q;
  assign clear_fifo_o   = live & (state_q == CLEAR) & (pick_store_q != dir_q);
  assign src_start_o    = live & (state_q == START) & ~pick_store_q;
  assign sink_start_o   = live & (state_q == START) &  pick_store_q;
  assign phase_done_o   = live & (state_q == WAIT)  &  done_sel;
  assign job_done_o     = live & (state_q == DONE);
  assign busy_o         = (state_q != IDLE) & ~clear_i;

`ifdef NEUREKA_SEQ_PERF_CNT_EN
  logic [CNT_W-1:0] wait_cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      wait_cnt_q <= '0;
    else if (clear_i || accept)
      wait_cnt_q <= '0;
    else if (enable_i && ((state_q == WAIT) || (state_q == DRAIN)) && !(&wait_cnt_q))
      wait_cnt_q <= wait_cnt_q + 1'b1;
  end

  assign wait_cycles_o = wait_cnt_q;
`endif

endmodule

// File: tb/tb_neureka_streamer_sequencer.sv
// Directed bench for the streamer sequencer: latency, priority, drain,
// enable freeze, soft clear and async reset.
module tb_neureka_streamer_sequencer;

  logic       clk = 1'b0;
  logic       rst, clear, enable;
  logic       job_valid, job_ready;
  logic [4:0] job_mask;
  logic       job_wmem, job_fw;
  logic [2:0] ld_which_sel;
  logic       ld_st_sel, wmem_sel;
  logic       clear_source, clear_sink, clear_fifo;
  logic       src_start, sink_start;
  logic       src_done, sink_done, fifo_empty;
  logic       phase_done, job_done, busy;
`ifdef NEUREKA_SEQ_PERF_CNT_EN
  logic [31:0] wait_cycles;
`endif

  int tests  = 0;
  int errors = 0;
  int pd_cnt = 0;

  localparam logic [6:0] P_NONE  = 7'b0000000;
  localparam logic [6:0] P_CSRC  = 7'b1000000;
  localparam logic [6:0] P_CSNK  = 7'b0100000;
  localparam logic [6:0] P_CFIFO = 7'b0010000;
  localparam logic [6:0] P_SSTRT = 7'b0001000;
  localparam logic [6:0] P_KSTRT = 7'b0000100;
  localparam logic [6:0] P_PDONE = 7'b0000010;
  localparam logic [6:0] P_JDONE = 7'b0000001;

  always #5 clk = ~clk;

  neureka_streamer_sequencer #(.CNT_W(32), .FW_EN_DEFAULT(1'b1)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .clear_i        (clear),
    .enable_i       (enable),
    .job_valid_i    (job_valid),
    .job_ready_o    (job_ready),
    .job_mask_i     (job_mask),
    .job_wmem_i     (job_wmem),
    .job_fw_i       (job_fw),
    .ld_which_sel_o (ld_which_sel),
    .ld_st_sel_o    (ld_st_sel),
    .wmem_sel_o     (wmem_sel),
    .clear_source_o (clear_source),
    .clear_sink_o   (clear_sink),
    .clear_fifo_o   (clear_fifo),
    .src_start_o    (src_start),
    .sink_start_o   (sink_start),
    .src_done_i     (src_done),
    .sink_done_i    (sink_done),
    .fifo_empty_i   (fifo_empty),
    .phase_done_o   (phase_done),
    .job_done_o     (job_done),
    .busy_o         (busy)
`ifdef NEUREKA_SEQ_PERF_CNT_EN
    ,
    .wait_cycles_o  (wait_cycles)
`endif
  );

  always @(negedge clk) if (phase_done) pd_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] pulses();
    return {clear_source, clear_sink, clear_fifo, src_start, sink_start, phase_done, job_done};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a job in an IDLE cycle; returns settled in the following PICK cycle.
  task automatic accept_job(input logic [4:0] m, input logic wm, input logic fw);
    job_valid = 1'b1; job_mask = m; job_wmem = wm; job_fw = fw;
    #1;
    check("ready", job_ready, 1'b1);
    tick();
    job_valid = 1'b0;
    #1;
  endtask

  // Called settled in a CLEAR cycle; returns settled in the following PICK cycle.
  task automatic run_phase(input string tag, input logic [2:0] which, input logic st,
                           input logic wm, input logic [6:0] clr, input int wait_n);
    check({tag, "_clr"},   pulses(), clr);
    check({tag, "_which"}, ld_which_sel, which);
    check({tag, "_st"},    ld_st_sel, st);
    check({tag, "_wmem"},  wmem_sel, wm);
    tick();
    check({tag, "_start"}, pulses(), st ? P_KSTRT : P_SSTRT);
    for (int i = 0; i < wait_n; i++) begin
      tick();
      check({tag, "_wait"}, pulses(), P_NONE);
    end
    tick();
    if (st) sink_done = 1'b1; else src_done = 1'b1;
    #1;
    check({tag, "_pdone"}, pulses(), P_PDONE);
    tick();
    src_done = 1'b0; sink_done = 1'b0;
    #1;
    check({tag, "_pick"}, pulses(), P_NONE);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; clear = 1'b0; enable = 1'b1;
    job_valid = 1'b0; job_mask = '0; job_wmem = 1'b0; job_fw = 1'b0;
    src_done = 1'b0; sink_done = 1'b0; fifo_empty = 1'b1;
    #2;
    check("rst_which",  ld_which_sel, 3'd0);
    check("rst_pulses", pulses(), P_NONE);
    check("rst_busy",   busy, 1'b0);
    check("rst_ready",  job_ready, 1'b1);
    tick(); tick();
    rst = 1'b0;
    tick();

    // Single feat phase, done three cycles after start.
    accept_job(5'b00001, 1'b0, 1'b0);
    check("t1_pick_busy", busy, 1'b1);
    tick();
    run_phase("t1", 3'd0, 1'b0, 1'b0, P_CSRC, 2);
    tick();
    check("t1_jdone", pulses(), P_JDONE);
    tick();
    check("t1_idle", busy, 1'b0);

    // Four load phases in priority order.
    pd_cnt = 0;
    accept_job(5'b01111, 1'b0, 1'b0);
    tick(); run_phase("t3p0", 3'd0, 1'b0, 1'b0, P_CSRC, 0);
    tick(); run_phase("t3p1", 3'd1, 1'b0, 1'b0, P_CSRC, 1);
    tick(); run_phase("t3p2", 3'd2, 1'b0, 1'b0, P_CSRC, 0);
    tick(); run_phase("t3p3", 3'd3, 1'b0, 1'b0, P_CSRC, 2);
    tick();
    check("t3_jdone", pulses(), P_JDONE);
    check("t3_pdcnt", pd_cnt, 4);
    tick();

    // Empty mask: job_done at T+2, selects keep the last phase's values.
    accept_job(5'b00000, 1'b1, 1'b1);
    check("t4_pick", pulses(), P_NONE);
    tick();
    check("t4_jdone", pulses(), P_JDONE);
    check("t4_which", ld_which_sel, 3'd3);
    check("t4_wmem",  wmem_sel, 1'b0);
    tick();
    check("t4_idle", busy, 1'b0);

    // Merged feat+weight, then store after draining the FIFO.
    accept_job(5'b10011, 1'b1, 1'b1);
    tick();
    run_phase("t2fw", 3'd4, 1'b0, 1'b1, P_CSRC, 2);
    fifo_empty = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t2_drain", pulses(), P_NONE);
      check("t2_drain_busy", busy, 1'b1);
    end
    tick();
    fifo_empty = 1'b1;
    #1;
    check("t2_drain_last", pulses(), P_NONE);
    tick();
    run_phase("t2st", 3'd0, 1'b1, 1'b0, P_CSNK | P_CFIFO, 3);
    tick();
    check("t2_jdone", pulses(), P_JDONE);
`ifdef NEUREKA_SEQ_PERF_CNT_EN
    check("t2_waitcyc", wait_cycles, 32'd11);
`endif
    tick();
`ifdef NEUREKA_SEQ_PERF_CNT_EN
    check("t2_waitcyc_hold", wait_cycles, 32'd11);
`endif

    // Soft clear while idle resets direction and selects.
    clear = 1'b1;
    #1;
    check("t5_clr_ready", job_ready, 1'b0);
    tick();
    clear = 1'b0;
    #1;
    check("t5_clr_st", ld_st_sel, 1'b0);

    // Freeze in START, then abort in WAIT.
    pd_cnt = 0;
    accept_job(5'b00001, 1'b0, 1'b0);
    tick();
    check("t5_clear", pulses(), P_CSRC);
    tick();
    enable = 1'b0;
    #1;
    check("t5_dis_start", pulses(), P_NONE);
    tick();
    check("t5_dis_hold", pulses(), P_NONE);
    check("t5_dis_busy", busy, 1'b1);
    enable = 1'b1;
    #1;
    check("t5_en_start", pulses(), P_SSTRT);
    tick();
    check("t5_wait", pulses(), P_NONE);
    tick();
    clear = 1'b1; src_done = 1'b1;
    #1;
    check("t5_abort_pulses", pulses(), P_NONE);
    tick();
    clear = 1'b0;
    #1;
    check("t5_abort_ready", job_ready, 1'b1);
    check("t5_abort_busy",  busy, 1'b0);
    check("t5_abort_pulses2", pulses(), P_NONE);
    check("t5_abort_pdcnt", pd_cnt, 0);
    src_done = 1'b0;
    tick();

    // Async reset mid-job.
    accept_job(5'b00010, 1'b1, 1'b0);
    tick();
    check("t6_wmem", wmem_sel, 1'b1);
    check("t6_which", ld_which_sel, 3'd1);
    tick(); tick();
    rst = 1'b1;
    #1;
    check("t6_rst_which",  ld_which_sel, 3'd0);
    check("t6_rst_wmem",   wmem_sel, 1'b0);
    check("t6_rst_busy",   busy, 1'b0);
    check("t6_rst_pulses", pulses(), P_NONE);
    tick();
    rst = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
